key_event_decoder: RTL

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_event_decoder.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/key_event_decoder.sv
// PS/2 set-2 scancode decoder: folds E0/F0/E1 prefixes into key events,
// filters typematic repeats, tracks shift and maps printable presses to ASCII.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for the first byte of a sequence
// EXT     | E0 seen, next byte is an extended make or F0
// BRK     | F0 seen, next byte is a non-extended break
// EXT_BRK | E0 F0 seen, next byte is an extended break
// PAUSE   | E1 seen, swallowing the rest of the Pause sequence
module key_event_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic       fpgaclk,
  input  logic       rst,
  input  logic [7:0] scancode,
  input  logic       scan_vld,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_vld,
  output logic [7:0] ascii,
  output logic       ascii_vld,
  output logic       shift_held
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    PAUSE   = 3'd4
  } state_t;

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [2:0]    pause_q, pause_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    held_code_q, held_code_d;
  logic          held_ext_q, held_ext_d;
  logic          held_valid_q, held_valid_d;
  logic          lshift_q, lshift_d;
  logic          rshift_q, rshift_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_ext_q, key_ext_d;
  logic          key_break_q, key_break_d;
  logic          key_vld_q, key_vld_d;
  logic [7:0]    ascii_q, ascii_d;
  logic          ascii_vld_q, ascii_vld_d;

  logic          ev_fire, ev_ext, ev_brk, is_held;
  logic [8:0]    lut;

  // Returns {printable, lowercase/plain character}.
  function automatic logic [8:0] ascii_lut(input logic [7:0] code);
    case (code)
      8'h1C: ascii_lut = {1'b1, 8'h61};
      8'h32: ascii_lut = {1'b1, 8'h62};
      8'h21: ascii_lut = {1'b1, 8'h63};
      8'h23: ascii_lut = {1'b1, 8'h64};
      8'h24: ascii_lut = {1'b1, 8'h65};
      8'h2B: ascii_lut = {1'b1, 8'h66};
      8'h34: ascii_lut = {1'b1, 8'h67};
      8'h33: ascii_lut = {1'b1, 8'h68};
      8'h43: ascii_lut = {1'b1, 8'h69};
      8'h3B: ascii_lut = {1'b1, 8'h6A};
      8'h42: ascii_lut = {1'b1, 8'h6B};
      8'h4B: ascii_lut = {1'b1, 8'h6C};
      8'h3A: ascii_lut = {1'b1, 8'h6D};
      8'h31: ascii_lut = {1'b1, 8'h6E};
      8'h44: ascii_lut = {1'b1, 8'h6F};
      8'h4D: ascii_lut = {1'b1, 8'h70};
      8'h15: ascii_lut = {1'b1, 8'h71};
      8'h2D: ascii_lut = {1'b1, 8'h72};
      8'h1B: ascii_lut = {1'b1, 8'h73};
      8'h2C: ascii_lut = {1'b1, 8'h74};
      8'h3C: ascii_lut = {1'b1, 8'h75};
      8'h2A: ascii_lut = {1'b1, 8'h76};
      8'h1D: ascii_lut = {1'b1, 8'h77};
      8'h22: ascii_lut = {1'b1, 8'h78};
      8'h35: ascii_lut = {1'b1, 8'h79};
      8'h1A: ascii_lut = {1'b1, 8'h7A};
      8'h45: ascii_lut = {1'b1, 8'h30};
      8'h16: ascii_lut = {1'b1, 8'h31};
      8'h1E: ascii_lut = {1'b1, 8'h32};
      8'h26: ascii_lut = {1'b1, 8'h33};
      8'h25: ascii_lut = {1'b1, 8'h34};
      8'h2E: ascii_lut = {1'b1, 8'h35};
      8'h36: ascii_lut = {1'b1, 8'h36};
      8'h3D: ascii_lut = {1'b1, 8'h37};
      8'h3E: ascii_lut = {1'b1, 8'h38};
      8'h46: ascii_lut = {1'b1, 8'h39};
      8'h29: ascii_lut = {1'b1, 8'h20};
      8'h5A: ascii_lut = {1'b1, 8'h0D};
      default: ascii_lut = 9'h000;
    endcase
  endfunction

  always_ff @(posedge fpgaclk) begin
    if (rst) begin
      state_q      <= IDLE;
      pause_q      <= '0;
      to_q         <= '0;
      held_code_q  <= '0;
      held_ext_q   <= 1'b0;
      held_valid_q <= 1'b0;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      key_code_q   <= '0;
      key_ext_q    <= 1'b0;
      key_break_q  <= 1'b0;
      key_vld_q    <= 1'b0;
      ascii_q      <= '0;
      ascii_vld_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pause_q      <= pause_d;
      to_q         <= to_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      held_valid_q <= held_valid_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_break_q  <= key_break_d;
      key_vld_q    <= key_vld_d;
      ascii_q      <= ascii_d;
      ascii_vld_q  <= ascii_vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pause_d = pause_q;
    to_d    = to_q;
    ev_fire = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;

    if (scan_vld) begin
      // A byte always wins over a timeout expiring in the same cycle.
      to_d = '0;
      case (state_q)
        IDLE: begin
          case (scancode)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = PAUSE;
              pause_d = '0;
            end
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_d = IDLE;
            default: ev_fire = 1'b1;
          endcase
        end
        EXT: begin
          case (scancode)
            8'hF0: state_d = EXT_BRK;
            8'hE0: state_d = EXT;
            default: begin
              ev_fire = 1'b1;
              ev_ext  = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
        BRK: begin
          ev_fire = 1'b1;
          ev_brk  = 1'b1;
          state_d = IDLE;
        end
        EXT_BRK: begin
          ev_fire = 1'b1;
          ev_ext  = 1'b1;
          ev_brk  = 1'b1;
          state_d = IDLE;
        end
        PAUSE: begin
          if (pause_q == 3'd6) begin
            pause_d = '0;
            state_d = IDLE;
          end else begin
            pause_d = pause_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (to_q == TO_LAST) begin
        to_d    = '0;
        pause_d = '0;
        state_d = IDLE;
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end
  end

  always_comb begin
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
    held_valid_d = held_valid_q;
    lshift_d     = lshift_q;
    rshift_d     = rshift_q;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_break_d  = key_break_q;
    key_vld_d    = 1'b0;
    ascii_d      = ascii_q;
    ascii_vld_d  = 1'b0;
    is_held      = held_valid_q && (held_code_q == scancode) && (held_ext_q == ev_ext);
    lut          = ascii_lut(scancode);

    if (ev_fire && (ev_brk || !is_held)) begin
      key_code_d  = scancode;
      key_ext_d   = ev_ext;
      key_break_d = ev_brk;
      key_vld_d   = 1'b1;
      if (ev_brk) begin
        if (is_held) held_valid_d = 1'b0;
        if (!ev_ext && scancode == 8'h12) lshift_d = 1'b0;
        if (!ev_ext && scancode == 8'h59) rshift_d = 1'b0;
      end else begin
        held_code_d  = scancode;
        held_ext_d   = ev_ext;
        held_valid_d = 1'b1;
        if (!ev_ext && scancode == 8'h12) lshift_d = 1'b1;
        if (!ev_ext && scancode == 8'h59) rshift_d = 1'b1;
        if (!ev_ext && lut[8]) begin
          ascii_vld_d = 1'b1;
          // Shift state as it stood before this byte selects uppercase letters.
          if ((lshift_q || rshift_q) && lut[7:0] >= 8'h61)
            ascii_d = lut[7:0] - 8'h20;
          else
            ascii_d = lut[7:0];
        end
      end
    end
  end

  assign key_code   = key_code_q;
  assign key_ext    = key_ext_q;
  assign key_break  = key_break_q;
  assign key_vld    = key_vld_q;
  assign ascii      = ascii_q;
  assign ascii_vld  = ascii_vld_q;
  assign shift_held = lshift_q | rshift_q;

endmodule
